// File: rtl/rom_fetch_master_pkg.sv
// Shared definitions for the ROM fetch bus master: FSM encoding, active-low bus
// levels, reset polarity and default geometry. Optional timeout feature is
// enabled with the ROM_FETCH_TIMEOUT_EN macro (see rom_fetch_master.sv).
package rom_fetch_master_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAccess  = 2'd1,
    StRecover = 2'd2
  } state_e;

  // Bus strobes (cs_, as_, rdy_) are active low.
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // Level of the synchronous reset input that forces the reset state.
  localparam logic RESET_ACTIVE = 1'b1;

  // ROM geometry: 2^11 32-bit words = 8 KiB.
  localparam int unsigned ROM_ADDR_W = 11;
  localparam int unsigned ROM_DATA_W = 32;

  // ACCESS cycles without rdy_ before the optional abort.
  localparam int unsigned DEFAULT_TIMEOUT = 16;

  // True when a client byte address is word aligned and lies inside the ROM.
  function automatic logic addr_in_rom(input logic [31:0] byte_addr,
                                       input int unsigned addr_w);
    logic [31:0] above_rom;
    above_rom = byte_addr >> (addr_w + 2);
    return (byte_addr[1:0] == 2'b00) && (above_rom == '0);
  endfunction

endpackage

// File: rtl/rom_fetch_master.sv
// ROM fetch bus master. Accepts a byte-address read request from a client, checks
// alignment and range, runs one cs_/as_/rdy_ bus read and returns a single-cycle
// response. All outputs come straight from registers.
// Optional feature: define ROM_FETCH_TIMEOUT_EN to abort an ACCESS that sees no
// rdy_ for TIMEOUT cycles; without it ACCESS waits indefinitely.
module rom_fetch_master
  import rom_fetch_master_pkg::*;
#(
  parameter int unsigned ADDR_W = ROM_ADDR_W,
  parameter int unsigned DATA_W = ROM_DATA_W
`ifdef ROM_FETCH_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
`endif
) (
  input  logic              clk,
  input  logic              reset,
  // Client side
  input  logic              req,
  input  logic [31:0]       req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  // ROM slave bus (active-low strobes)
  output logic              cs_,
  output logic              as_,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rdy_
);

  state_e              state_q, state_d;
  logic                cs_q, cs_d;
  logic                as_q, as_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;
  logic                resp_err_q, resp_err_d;
  logic                req_ok;

`ifdef ROM_FETCH_TIMEOUT_EN
  // Counter holds 0..TIMEOUT-1.
  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  assign req_ok = addr_in_rom(req_addr, ADDR_W);

  // Next-state, bus strobes and response capture.
  always_comb begin
    state_d     = state_q;
    cs_d        = cs_q;
    as_d        = as_q;
    addr_d      = addr_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
`ifdef ROM_FETCH_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    case (state_q)
      StIdle: begin
        if (req) begin
          if (!req_ok) begin
            // Rejected request: answer with an error, never touch the bus.
            resp_err_d  = 1'b1;
            resp_data_d = '0;
            state_d     = StRecover;
          end else begin
            addr_d  = req_addr[ADDR_W+1:2];
            cs_d    = ENABLE_;
            as_d    = ENABLE_;
            state_d = StAccess;
`ifdef ROM_FETCH_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end

      StAccess: begin
        if (rdy_ == ENABLE_) begin
          // Data wins even on the cycle the timeout would fire.
          resp_data_d = rd_data;
          resp_err_d  = 1'b0;
          cs_d        = DISABLE_;
          as_d        = DISABLE_;
          state_d     = StRecover;
`ifdef ROM_FETCH_TIMEOUT_EN
        end else if (cnt_q == CntLast) begin
          resp_data_d = '0;
          resp_err_d  = 1'b1;
          cs_d        = DISABLE_;
          as_d        = DISABLE_;
          state_d     = StRecover;
        end else begin
          cnt_d = cnt_q + CntW'(1);
`endif
        end
      end

      // One turnaround cycle; a stale rdy_ from the slave is ignored here.
      StRecover: begin
        state_d = StIdle;
      end

      default: begin
        cs_d    = DISABLE_;
        as_d    = DISABLE_;
        state_d = StIdle;
      end
    endcase

    // Handshake outputs are registered copies of where the FSM is heading.
    resp_valid_d = (state_d == StRecover);
    req_ready_d  = (state_d == StIdle);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset == RESET_ACTIVE) begin
      state_q      <= StIdle;
      cs_q         <= DISABLE_;
      as_q         <= DISABLE_;
      addr_q       <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cs_q         <= cs_d;
      as_q         <= as_d;
      addr_q       <= addr_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

`ifdef ROM_FETCH_TIMEOUT_EN
  // Wait-state counter for the ACCESS abort.
  always_ff @(posedge clk) begin
    if (reset == RESET_ACTIVE) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign cs_        = cs_q;
  assign as_        = as_q;
  assign addr       = addr_q;
  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_rom_fetch_master.sv
// Self-checking bench for rom_fetch_master: directed vector table, hand-written
// corner sequences and randomized transactions against a transaction-level model.
module tb_rom_fetch_master;

  logic        clk;
  logic        reset;
  logic        req;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        cs_;
  logic        as_;
  logic [10:0] addr;
  logic [31:0] rd_data;
  logic        rdy_;

  int checks = 0;
  int errors = 0;

  // Slave model state
  int slave_wait  = 0;
  int sk          = 0;
  bit prev_cs_low = 0;
  bit slave_noise = 0;

`ifdef ROM_FETCH_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif
  localparam int Tmo = 16;

  rom_fetch_master dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_data (resp_data),
    .resp_err  (resp_err),
    .cs_       (cs_),
    .as_       (as_),
    .addr      (addr),
    .rd_data   (rd_data),
    .rdy_      (rdy_)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ROM contents seen by the slave model.
  function automatic logic [31:0] rom_word(input logic [31:0] w);
    if (w == 32'd4) return 32'hDEAD_BEEF;
    return 32'hA5A5_0000 | w;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Slave: rdy_ low once cs_ has been seen low for 2+slave_wait negedges; rdy_ stays
  // low one extra cycle after cs_ rises (stale); optional random rdy_ noise when idle.
  task automatic slave_tick();
    if (cs_ === 1'b0) begin
      sk++;
      if (sk >= 2 + slave_wait) begin
        rdy_    = 1'b0;
        rd_data = rom_word({21'b0, addr});
      end else begin
        rdy_    = 1'b1;
        rd_data = $urandom;
      end
      prev_cs_low = 1'b1;
    end else begin
      sk = 0;
      if (!(prev_cs_low && rdy_ === 1'b0)) begin
        if (slave_noise) rdy_ = 1'($urandom_range(0, 1));
        else rdy_ = 1'b1;
      end
      rd_data     = $urandom;
      prev_cs_low = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    slave_tick();
  endtask

  // Transaction-level reference: ticks to resp_valid, cs_-low cycles, result.
  task automatic model(input logic [31:0] a, input int w, output bit err,
                       output logic [31:0] data, output int lat, output int cs,
                       output logic [10:0] waddr);
    bit ok;
    ok    = (a % 4 == 0) && (a < 32'd8192);
    waddr = 11'((a / 4) % 2048);
    if (!ok) begin
      err = 1; data = 0; lat = 1; cs = 0;
    end else if (TmoEn && (2 + w > Tmo)) begin
      err = 1; data = 0; lat = Tmo + 1; cs = Tmo;
    end else begin
      err = 0; data = rom_word(a / 4); lat = 3 + w; cs = 2 + w;
    end
  endtask

  // Issue one request at an IDLE negedge and check the whole transaction.
  task automatic do_txn(input string name, input logic [31:0] a, input int w,
                        input bit hold, input bit exp_err, input logic [31:0] exp_data,
                        input int exp_lat, input int exp_cs, input logic [10:0] exp_waddr);
    int          lat;
    int          cs_cnt;
    bit          addr_bad;
    bit          strobe_bad;
    logic [31:0] got_data;
    logic        got_err;
    lat = -1; cs_cnt = 0; addr_bad = 0; strobe_bad = 0;
    got_data = 'x; got_err = 'x;
    chk({name, ".req_ready"}, 64'(req_ready), 64'd1);
    req        = 1'b1;
    req_addr   = a;
    slave_wait = w;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (n == 1) begin
        req      = hold;
        req_addr = $urandom;
      end
      if (cs_ === 1'b0) begin
        cs_cnt++;
        if (addr !== exp_waddr) addr_bad = 1;
      end
      if (cs_ !== as_) strobe_bad = 1;
      if (resp_valid === 1'b1) begin
        lat      = n;
        got_data = resp_data;
        got_err  = resp_err;
        break;
      end
    end
    chk({name, ".latency"}, 64'(lat), 64'(exp_lat));
    chk({name, ".resp_data"}, 64'(got_data), 64'(exp_data));
    chk({name, ".resp_err"}, 64'(got_err), 64'(exp_err));
    chk({name, ".cs_cycles"}, 64'(cs_cnt), 64'(exp_cs));
    chk({name, ".addr_stable"}, 64'(addr_bad), 64'd0);
    chk({name, ".as_eq_cs"}, 64'(strobe_bad), 64'd0);
    tick();
    chk({name, ".after{valid,ready,cs_}"}, 64'({resp_valid, req_ready, cs_}), 64'b011);
    req = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a;
    int          w;
    bit          hold;
    bit          err;
    logic [31:0] data;
    int          lat;
    int          cs;
    logic [10:0] waddr;
  } vec_t;

  vec_t vecs[10];

  initial begin
    bit          m_err;
    logic [31:0] m_data;
    int          m_lat;
    int          m_cs;
    logic [10:0] m_waddr;
    logic [31:0] ra;
    bit          bad;

    vecs[0] = '{32'h0000_0010, 0, 0, 0, 32'hDEAD_BEEF, 3, 2, 11'd4};
    vecs[1] = '{32'h0000_0006, 0, 0, 1, 32'h0000_0000, 1, 0, 11'd1};
    vecs[2] = '{32'h0000_2000, 0, 0, 1, 32'h0000_0000, 1, 0, 11'd0};
    vecs[3] = '{32'h0000_1FFC, 1, 0, 0, 32'hA5A5_07FF, 4, 3, 11'h7FF};
    vecs[4] = '{32'h0000_0000, 3, 1, 0, 32'hA5A5_0000, 6, 5, 11'd0};
    vecs[5] = '{32'h0000_0008, 0, 1, 0, 32'hA5A5_0002, 3, 2, 11'd2};
    vecs[6] = '{32'h8000_0000, 0, 1, 1, 32'h0000_0000, 1, 0, 11'd0};
    vecs[7] = '{32'h0000_1FFF, 0, 0, 1, 32'h0000_0000, 1, 0, 11'h7FF};
    vecs[8] = '{32'h4000_0004, 2, 0, 1, 32'h0000_0000, 1, 0, 11'd1};
    vecs[9] = '{32'h0000_0004, 2, 0, 0, 32'hA5A5_0001, 5, 4, 11'd1};

    // Reset state
    reset = 1'b1; req = 1'b0; req_addr = '0; rdy_ = 1'b1; rd_data = '0;
    repeat (3) tick();
    chk("rst.cs_", 64'(cs_), 64'd1);
    chk("rst.as_", 64'(as_), 64'd1);
    chk("rst.addr", 64'(addr), 64'd0);
    chk("rst.resp_valid", 64'(resp_valid), 64'd0);
    chk("rst.resp_data", 64'(resp_data), 64'd0);
    chk("rst.resp_err", 64'(resp_err), 64'd0);
    chk("rst.req_ready", 64'(req_ready), 64'd1);
    reset = 1'b0;
    tick();
    chk("post_rst.req_ready", 64'(req_ready), 64'd1);

    // Directed table; entries 4..6 run back-to-back with req held high
    foreach (vecs[i]) begin
      do_txn($sformatf("vec%0d", i), vecs[i].a, vecs[i].w, vecs[i].hold, vecs[i].err,
             vecs[i].data, vecs[i].lat, vecs[i].cs, vecs[i].waddr);
    end

    // rdy_ wiggling while idle must not produce a response or bus cycle
    slave_noise = 1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (resp_valid !== 1'b0 || cs_ !== 1'b1) bad = 1;
    end
    slave_noise = 0;
    tick();
    chk("idle_rdy_noise", 64'(bad), 64'd0);

    // Reset in ACCESS on the very edge where rdy_ is low
    req = 1'b1; req_addr = 32'h0000_0020; slave_wait = 1;
    tick();
    req = 1'b0;
    tick();
    tick();
    chk("midrst.rdy_low_before_reset", 64'(rdy_), 64'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst.{cs_,as_}", 64'({cs_, as_}), 64'b11);
    chk("midrst.resp_valid", 64'(resp_valid), 64'd0);
    chk("midrst.req_ready", 64'(req_ready), 64'd1);
    chk("midrst.resp_data", 64'(resp_data), 64'd0);
    chk("midrst.addr", 64'(addr), 64'd0);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (resp_valid !== 1'b0 || cs_ !== 1'b1) bad = 1;
    end
    chk("midrst.no_late_resp", 64'(bad), 64'd0);
    do_txn("midrst.next", 32'h0000_0024, 0, 0, 0, 32'hA5A5_0009, 3, 2, 11'd9);

`ifdef ROM_FETCH_TIMEOUT_EN
    model(32'h0000_0030, 14, m_err, m_data, m_lat, m_cs, m_waddr);
    do_txn("tmo.rdy_last_cycle", 32'h0000_0030, 14, 0, m_err, m_data, m_lat, m_cs, m_waddr);
    model(32'h0000_0034, 1000, m_err, m_data, m_lat, m_cs, m_waddr);
    do_txn("tmo.stuck", 32'h0000_0034, 1000, 0, m_err, m_data, m_lat, m_cs, m_waddr);
    do_txn("tmo.after", 32'h0000_0010, 0, 0, 0, 32'hDEAD_BEEF, 3, 2, 11'd4);
`endif

    // Randomized transactions against the model
    for (int i = 0; i < 40; i++) begin
      int cls;
      int w;
      cls = $urandom_range(0, 9);
      if (cls < 5) ra = 32'($urandom_range(0, 2047)) * 4;
      else if (cls < 7) ra = 32'($urandom_range(0, 8191)) | 32'($urandom_range(1, 3));
      else if (cls < 9) ra = 32'h2000 + $urandom_range(0, 32'h00FF_FFFF);
      else ra = $urandom;
      w = $urandom_range(0, 6);
      model(ra, w, m_err, m_data, m_lat, m_cs, m_waddr);
      do_txn($sformatf("rnd%0d@%08h", i, ra), ra, w, 1'($urandom_range(0, 1)),
             m_err, m_data, m_lat, m_cs, m_waddr);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
